// File: rtl/gpio_func_seq_if.sv
// gpio_func_seq_if: config bus, peripheral activity and pin-mux enables of the function sequencer
interface gpio_func_seq_if;
  logic       cfg_wr;
  logic [5:0] cfg_data;
  logic [5:0] periph_busy;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;
  logic [5:0] en_vec;
  logic       EN_UART, EN_I2C, EN_SPI, EN_PWM_OUTB0, EN_PWM_OUTA0, EN_TMR_IN0;
  modport master (
    output cfg_wr, cfg_data, periph_busy,
    input  cfg_ready, cfg_done, cfg_err, en_vec,
    input  EN_UART, EN_I2C, EN_SPI, EN_PWM_OUTB0, EN_PWM_OUTA0, EN_TMR_IN0
  );
  modport slave (
    input  cfg_wr, cfg_data, periph_busy,
    output cfg_ready, cfg_done, cfg_err, en_vec,
    output EN_UART, EN_I2C, EN_SPI, EN_PWM_OUTB0, EN_PWM_OUTA0, EN_TMR_IN0
  );
endinterface

// File: rtl/gpio_func_seq.sv
// gpio_func_seq: applies a target alternate-function map one enable at a time, lowest bit first
module gpio_func_seq #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  gpio_func_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, SETTLE} state_t;
  state_t state, state_n;
  logic [5:0] target, target_n, en, en_n, pending, elig, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic done, done_n, err, err_n;
  assign pending = target ^ en;
  // a disable waits while its peripheral is active; enables never wait
  assign elig = pending & ~(en & bus.periph_busy);
  assign pick = elig & (~elig + 6'd1);
  always_comb begin
    state_n = state;
    target_n = target;
    en_n = en;
    cnt_n = cnt;
    done_n = 1'b0;
    err_n = bus.cfg_wr && state != IDLE;
    case (state)
      IDLE: if (bus.cfg_wr) begin
        target_n = bus.cfg_data;
        state_n = SCAN;
      end
      SCAN: if (pending == 6'd0) begin
        state_n = IDLE;
        done_n = 1'b1;
      end else if (elig != 6'd0) begin
        en_n = en ^ pick;
        state_n = SETTLE_CYCLES == 0 ? SCAN : SETTLE;
      end
      SETTLE: begin
        cnt_n = cnt == CNT_W'(SETTLE_CYCLES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CNT_W'(SETTLE_CYCLES - 1) ? SCAN : SETTLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      target <= '0;
      en <= '0;
      cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      en <= en_n;
      cnt <= cnt_n;
      done <= done_n;
      err <= err_n;
    end
  end
  assign bus.cfg_ready = state == IDLE;
  assign bus.cfg_done = done;
  assign bus.cfg_err = err;
  assign bus.en_vec = en;
  assign {bus.EN_TMR_IN0, bus.EN_PWM_OUTA0, bus.EN_PWM_OUTB0, bus.EN_SPI, bus.EN_I2C, bus.EN_UART} = en;
endmodule

// File: tb/tb_gpio_func_seq.sv
// tb_gpio_func_seq: directed checks of the function sequencer with settle gaps of 4 and 0
module tb_gpio_func_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  gpio_func_seq_if a ();
  gpio_func_seq_if b ();
  gpio_func_seq #(.SETTLE_CYCLES(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst), .bus(a));
  gpio_func_seq #(.SETTLE_CYCLES(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write_a(input logic [5:0] d);
    a.cfg_wr = 1'b1;
    a.cfg_data = d;
    tick();
    a.cfg_wr = 1'b0;
  endtask
  initial begin
    logic [5:0] mixed [4];
    mixed = '{6'h04, 6'h06, 6'h02, 6'h22};
    a.cfg_wr = 1'b0; a.cfg_data = '0; a.periph_busy = '0;
    b.cfg_wr = 1'b0; b.cfg_data = '0; b.periph_busy = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_en", a.en_vec, 0);
    check("rst_ready", a.cfg_ready, 1);
    check("rst_done", a.cfg_done, 0);
    check("rst_err", a.cfg_err, 0);
    check("rst_en0", b.en_vec, 0);
    write_a(6'h05);
    tick();
    check("basic_e1_uart", a.EN_UART, 1);
    check("basic_e1_en", a.en_vec, 6'h01);
    repeat (4) tick();
    check("basic_e5_en", a.en_vec, 6'h01);
    tick();
    check("basic_e6_spi", a.EN_SPI, 1);
    repeat (4) tick();
    check("basic_e10_done", a.cfg_done, 0);
    check("basic_e10_ready", a.cfg_ready, 0);
    tick();
    check("basic_e11_done", a.cfg_done, 1);
    check("basic_e11_ready", a.cfg_ready, 1);
    check("basic_e11_en", a.en_vec, 6'h05);
    tick();
    check("basic_done_pulse", a.cfg_done, 0);
    write_a(6'h22);
    tick();
    check("mixed_t0", a.en_vec, mixed[0]);
    a.cfg_wr = 1'b1;
    a.cfg_data = 6'h3F;
    tick();
    a.cfg_wr = 1'b0;
    check("reject_err", a.cfg_err, 1);
    tick();
    check("reject_err_pulse", a.cfg_err, 0);
    repeat (3) tick();
    check("mixed_t1", a.en_vec, mixed[1]);
    for (int k = 2; k < 4; k++) begin
      repeat (4) tick();
      check("mixed_hold", a.en_vec, mixed[k-1]);
      tick();
      check("mixed_tk", a.en_vec, mixed[k]);
    end
    repeat (5) tick();
    check("mixed_done", a.cfg_done, 1);
    check("reject_final", a.en_vec, 6'h22);
    write_a(6'h03);
    repeat (11) tick();
    check("prep_done", a.cfg_done, 1);
    check("prep_en", a.en_vec, 6'h03);
    a.periph_busy = 6'h01;
    write_a(6'h00);
    tick();
    check("busy_i2c_off", a.en_vec, 6'h01);
    repeat (10) tick();
    check("busy_hold_en", a.EN_UART, 1);
    check("busy_hold_ready", a.cfg_ready, 0);
    a.periph_busy = 6'h00;
    tick();
    check("busy_release", a.en_vec, 6'h00);
    repeat (4) tick();
    check("busy_pre_done", a.cfg_done, 0);
    tick();
    check("busy_done", a.cfg_done, 1);
    write_a(6'h05);
    tick();
    tick();
    check("rstmid_pre", a.en_vec, 6'h01);
    #2 rst = 1'b1;
    #1;
    check("rstmid_uart", a.EN_UART, 0);
    check("rstmid_en", a.en_vec, 0);
    check("rstmid_ready", a.cfg_ready, 1);
    #1 rst = 1'b0;
    repeat (12) tick();
    check("rstmid_quiet_en", a.en_vec, 0);
    check("rstmid_quiet_ready", a.cfg_ready, 1);
    b.cfg_wr = 1'b1;
    b.cfg_data = 6'h3F;
    tick();
    b.cfg_wr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("s0_step", b.en_vec, (32'd1 << i) - 1);
    end
    check("s0_e6_done", b.cfg_done, 0);
    tick();
    check("s0_e7_done", b.cfg_done, 1);
    check("s0_e7_ready", b.cfg_ready, 1);
    b.cfg_wr = 1'b1;
    tick();
    b.cfg_wr = 1'b0;
    tick();
    check("nochange_done", b.cfg_done, 1);
    check("nochange_en", b.en_vec, 6'h3F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
